fact_interface: RTL

FACT_INTERFACE -- requirements
Module: fact_interface

---
 rtl/fact_interface.sv | 123 ++++++++++++
 1 files changed

// File: rtl/fact_interface.sv
// Memory-mapped front end for a factorial unit: N/GO/STATUS/RESULT registers plus a three-state handshake FSM.
// Optional: define FACT_OVERFLOW_CHECK_EN to reject N > 12 (32-bit overflow) without starting the unit.
module fact_interface #(
  parameter int IWIDE = 4,
  parameter int OWIDE = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [1:0]       a,
  input  logic [31:0]      wd,
  output logic [31:0]      rd,
  output logic             fact_go,
  output logic [IWIDE-1:0] fact_n,
  input  logic             fact_done,
  input  logic [OWIDE-1:0] fact_out
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [IWIDE-1:0] n_q, n_d;
  logic [31:0]      result_q, result_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic busy;
  logic goWrite;
  logic nWrite;
  logic unusedWd;

  assign busy     = (state_q == START) || (state_q == WAIT);
  assign goWrite  = we && (a == 2'd1) && wd[0];
  assign nWrite   = we && (a == 2'd0);
  assign unusedWd = ^wd;

  assign fact_n  = n_q;
  assign fact_go = (state_q == START);

`ifdef FACT_OVERFLOW_CHECK_EN
  logic [31:0] nExt;
  logic        nOverflow;
  assign nExt      = 32'(n_q);
  assign nOverflow = (nExt > 32'd12);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      n_q      <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      n_q      <= n_d;
      result_q <= result_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  // N is only writable while idle, so the operand stays stable for the whole operation.
  always_comb begin
    state_d  = state_q;
    n_d      = n_q;
    result_d = result_q;
    done_d   = done_q;
    err_d    = err_q;

    case (state_q)
      IDLE: begin
        if (nWrite) begin
          n_d = wd[IWIDE-1:0];
        end
        if (goWrite) begin
          done_d = 1'b0;
          err_d  = 1'b0;
`ifdef FACT_OVERFLOW_CHECK_EN
          if (nOverflow) begin
            done_d   = 1'b1;
            err_d    = 1'b1;
            result_d = '0;
          end else begin
            state_d = START;
          end
`else
          state_d = START;
`endif
        end
      end
      START: begin
        state_d = WAIT;
      end
      WAIT: begin
        if (fact_done) begin
          result_d = 32'(fact_out);
          done_d   = 1'b1;
          state_d  = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    rd = '0;
    case (a)
      2'd0:    rd = 32'(n_q);
      2'd1:    rd = '0;
      2'd2:    rd = {29'b0, busy, err_q, done_q};
      2'd3:    rd = result_q;
      default: rd = '0;
    endcase
  end

endmodule
